multi_cycle_control_unit: RTL and testbench
===========================================

// Module: multi_cycle_control_unit
// PURPOSE
//  Main FSM of the multi-cycle RV32I core; writer side of the PC register interface (drives pc_update, pc_source).
//  Sequences IF/ID/EX/MEM/WB per opcode, emits all datapath enables and mux selects.
//  Issues exactly one pc_update pulse per retired instruction; halts on ecall when halt_req is set.
// PARAMETERS
//  OP_RTYPE  7'b0110011  R-type ALU opcode
//  OP_ITYPE  7'b0010011  I-type ALU opcode
//  OP_LOAD   7'b0000011  load opcode
//  OP_STORE  7'b0100011  store opcode
//  OP_BRANCH 7'b1100011  branch opcode
//  OP_JAL    7'b1101111  JAL opcode
//  OP_JALR   7'b1100111  JALR opcode
//  OP_ECALL  7'b1110011  ecall opcode
// PORTS
//  clk         in   1  clock, rising edge
//  reset       in   1  asynchronous, active-high reset
//  opcode      in   7  IR[6:0], stable from ID onward
//  alu_bcond   in   1  branch condition from ALU (valid in EX of a branch)
//  halt_req    in   1  ecall halt request from datapath (x17==10)
//  pc_update   out  1  PC write enable
//  pc_source   out  1  0: ALU result (comb.), 1: ALUOut register
//  i_or_d      out  1  memory address: 0 PC, 1 ALUOut
//  mem_read    out  1  memory read enable
//  mem_write   out  1  memory write enable
//  ir_write    out  1  IR load enable
//  reg_write   out  1  register file write enable
//  wb_sel      out  2  rd data: 00 ALUOut, 01 MDR, 10 ALU result (comb.)
//  alu_src_a   out  1  0 PC, 1 reg A
//  alu_src_b   out  2  00 reg B, 01 const 4, 10 imm
//  alu_op      out  2  00 add, 01 branch compare, 10 funct-decoded
//  is_halted   out  1  sticky halt flag
// BEHAVIOUR
//  State register only; outputs decoded combinationally from state, opcode, alu_bcond. Undriven selects = 0.
//  reset high: state<=IF asynchronously; pc_update, mem_read, mem_write, ir_write, reg_write, is_halted forced 0.
//  IF : mem_read=1, i_or_d=0, ir_write=1 -> ID.
//  ID : ALUOut<=PC+imm (src_a=0, src_b=10, op=00). ecall&halt_req -> HALT; else -> EX.
//  EX : R-type: src_a=1,src_b=00,op=10 -> WB.  I-type: src_a=1,src_b=10,op=10 -> WB.
//       load/store: src_a=1,src_b=10,op=00 -> MEM.  JALR: same -> WB.
//       branch: src_a=1,src_b=00,op=01; bcond=1: pc_update=1,pc_source=1 -> IF; bcond=0 -> BR_NT.
//       JAL: src_a=0,src_b=01 (PC+4); reg_write=1,wb_sel=10; pc_update=1,pc_source=1 -> IF.
//       ecall w/o halt_req, unknown opcode: PC+4 via ALU, pc_update=1,pc_source=0 -> IF (NOP).
//  BR_NT: ALU PC+4, pc_update=1, pc_source=0 -> IF.
//  MEM: i_or_d=1; load: mem_read=1 -> WB. store: mem_write=1, ALU PC+4, pc_update=1,pc_source=0 -> IF.
//  WB : R/I: reg_write=1,wb_sel=00; load: reg_write=1,wb_sel=01; both ALU PC+4, pc_update=1,pc_source=0.
//       JALR: ALU PC+4, reg_write=1,wb_sel=10, pc_update=1,pc_source=1 (target). All -> IF.
//  HALT: is_halted=1, all enables 0, no exit except reset.
//  CPI: R/I 4, load 5, store 4, branch taken 3 / not-taken 4, JAL 3, JALR 4, NOP 3.
//  Invariants: pc_update never in IF/ID/HALT; exactly one pc_update per instruction; mem_read & mem_write never both 1.
//  alu_bcond only sampled in EX of a branch; ignored elsewhere. halt_req only sampled in ID of ecall.
//  reset mid-instruction: no further enables after reset edge; first cycle after release is IF.
// TESTING
//  add x3,x1,x2 after reset -> states IF,ID,EX,WB; reg_write&pc_update only in cycle 4, pc_source=0.
//  lw -> 5 cycles; mem_read,i_or_d=1 in cycle 4; cycle 5 reg_write=1,wb_sel=01,pc_update=1.
//  beq with bcond=1 -> pc_update in cycle 3, pc_source=1; bcond=0 -> pc_update cycle 4, pc_source=0.
//  jal then jalr -> JAL: cycle 3 reg_write,wb_sel=10,pc_source=1; JALR: cycle 4 same outputs.
//  ecall with halt_req=1 -> HALT after ID, is_halted=1, no pc_update for 20 cycles; halt_req=0 -> NOP, 3 cycles.
//  reset asserted in MEM of sw (async, mid-cycle) -> mem_write drops immediately; after release IF with mem_read=1.

Source files
------------

// File: rtl/multi_cycle_control_unit.sv
// Main sequencing FSM of the multi-cycle RV32I core: walks IF/ID/EX/MEM/WB per opcode
// and decodes every datapath enable and mux select from the current state.
module multi_cycle_control_unit #(
  parameter logic [6:0] OP_RTYPE  = 7'b0110011,
  parameter logic [6:0] OP_ITYPE  = 7'b0010011,
  parameter logic [6:0] OP_LOAD   = 7'b0000011,
  parameter logic [6:0] OP_STORE  = 7'b0100011,
  parameter logic [6:0] OP_BRANCH = 7'b1100011,
  parameter logic [6:0] OP_JAL    = 7'b1101111,
  parameter logic [6:0] OP_JALR   = 7'b1100111,
  parameter logic [6:0] OP_ECALL  = 7'b1110011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       halt_req,
  output logic       pc_update,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       is_halted
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_BR_NT = 3'd5,
    S_HALT  = 3'd6
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Next state and combinational output decode; reset overrides all outputs to 0.
  always_comb begin
    state_d   = state_q;
    pc_update = 1'b0;
    pc_source = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op    = 2'b00;
    is_halted = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_ECALL && halt_req) ? S_HALT : S_EX;
      end
      S_EX: begin
        case (opcode)
          OP_RTYPE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_WB;
          end
          OP_ITYPE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE, OP_JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (opcode == OP_JALR) ? S_WB : S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            if (alu_bcond) begin
              pc_update = 1'b1;
              pc_source = 1'b1;
              state_d   = S_IF;
            end else begin
              state_d   = S_BR_NT;
            end
          end
          OP_JAL: begin
            alu_src_b = 2'b01;
            reg_write = 1'b1;
            wb_sel    = 2'b10;
            pc_update = 1'b1;
            pc_source = 1'b1;
            state_d   = S_IF;
          end
          // Non-halting ecall and unknown opcodes retire as a NOP.
          default: begin
            alu_src_b = 2'b01;
            pc_update = 1'b1;
            state_d   = S_IF;
          end
        endcase
      end
      S_BR_NT: begin
        alu_src_b = 2'b01;
        pc_update = 1'b1;
        state_d   = S_IF;
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (opcode == OP_LOAD) begin
          mem_read = 1'b1;
          state_d  = S_WB;
        end else begin
          mem_write = 1'b1;
          alu_src_b = 2'b01;
          pc_update = 1'b1;
          state_d   = S_IF;
        end
      end
      S_WB: begin
        alu_src_b = 2'b01;
        pc_update = 1'b1;
        reg_write = 1'b1;
        if (opcode == OP_JALR) begin
          wb_sel    = 2'b10;
          pc_source = 1'b1;
        end else if (opcode == OP_LOAD) begin
          wb_sel    = 2'b01;
        end
        state_d = S_IF;
      end
      S_HALT: begin
        is_halted = 1'b1;
        state_d   = S_HALT;
      end
      default: state_d = S_IF;
    endcase

    if (reset) begin
      pc_update = 1'b0;
      pc_source = 1'b0;
      i_or_d    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'b00;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      alu_op    = 2'b00;
      is_halted = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Self-checking bench for multi_cycle_control_unit: per-instruction cycle tables built
// from the instruction-level behaviour, directed scenarios plus a random instruction stream.
module tb_multi_cycle_control_unit;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_BRT, K_BRNT, K_JAL, K_JALR, K_NOP, K_ECNOP} kind_e;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       halt_req;
  logic       pc_update, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] wb_sel, alu_src_b, alu_op;
  logic       alu_src_a, is_halted;

  int checks = 0;
  int passed = 0;

  multi_cycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond), .halt_req(halt_req),
    .pc_update(pc_update), .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .is_halted(is_halted)
  );

  logic [14:0] obs;
  assign obs = {pc_update, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
                wb_sel, alu_src_a, alu_src_b, alu_op, is_halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int instr_len(kind_e k);
    case (k)
      K_LD:                      return 5;
      K_BRT, K_JAL, K_NOP, K_ECNOP: return 3;
      default:                   return 4;
    endcase
  endfunction

  function automatic logic [6:0] op_of(kind_e k);
    logic [6:0] r;
    case (k)
      K_R:          return OP_RTYPE;
      K_I:          return OP_ITYPE;
      K_LD:         return OP_LOAD;
      K_ST:         return OP_STORE;
      K_BRT, K_BRNT: return OP_BRANCH;
      K_JAL:        return OP_JAL;
      K_JALR:       return OP_JALR;
      K_ECNOP:      return OP_ECALL;
      default: begin
        do r = 7'($urandom);
        while (r == OP_RTYPE || r == OP_ITYPE || r == OP_LOAD || r == OP_STORE ||
               r == OP_BRANCH || r == OP_JAL || r == OP_JALR || r == OP_ECALL);
        return r;
      end
    endcase
  endfunction

  // Expected outputs in cycle c (1-based) of an instruction of kind k.
  function automatic logic [14:0] exp_out(kind_e k, int c);
    logic pu = 0, ps = 0, iod = 0, mr = 0, mw = 0, irw = 0, rw = 0, sa = 0;
    logic [1:0] wb = 2'b00, sb = 2'b00, op = 2'b00;
    bit retire4 = 0;
    if (c == 1) begin
      mr = 1; irw = 1;
    end else if (c == 2) begin
      sb = 2'b10;
    end else if (c == 3) begin
      case (k)
        K_R:  begin sa = 1; op = 2'b10; end
        K_I:  begin sa = 1; sb = 2'b10; op = 2'b10; end
        K_LD, K_ST, K_JALR: begin sa = 1; sb = 2'b10; end
        K_BRT:  begin sa = 1; op = 2'b01; pu = 1; ps = 1; end
        K_BRNT: begin sa = 1; op = 2'b01; end
        K_JAL:  begin sb = 2'b01; rw = 1; wb = 2'b10; pu = 1; ps = 1; end
        default: retire4 = 1;
      endcase
    end else if (c == 4) begin
      case (k)
        K_R, K_I: begin rw = 1; retire4 = 1; end
        K_LD:   begin iod = 1; mr = 1; end
        K_ST:   begin iod = 1; mw = 1; retire4 = 1; end
        K_BRNT: retire4 = 1;
        K_JALR: begin sb = 2'b01; rw = 1; wb = 2'b10; pu = 1; ps = 1; end
        default: ;
      endcase
    end else if (c == 5 && k == K_LD) begin
      rw = 1; wb = 2'b01; retire4 = 1;
    end
    if (retire4) begin
      sb = 2'b01; pu = 1;
    end
    return {pu, ps, iod, mr, mw, irw, rw, wb, sa, sb, op, 1'b0};
  endfunction

  // Runs one instruction starting in its IF cycle (at posedge+1); stop>0 ends early.
  task automatic run_instr(input kind_e k, input int stop);
    int n = instr_len(k);
    int pcu = 0;
    int last = (stop > 0) ? stop : n;
    logic [14:0] e;
    for (int c = 1; c <= last; c++) begin
      opcode    = (c == 1) ? 7'($urandom) : op_of(k);
      alu_bcond = (c == 3 && (k == K_BRT || k == K_BRNT)) ? (k == K_BRT) : 1'($urandom);
      halt_req  = (c == 2 && k == K_ECNOP) ? 1'b0 : 1'($urandom);
      if (k == K_NOP && c >= 2 && opcode == OP_ECALL) halt_req = 1'b0;
      #1;
      e = exp_out(k, c);
      checks++;
      if (obs !== e) $display("FAIL %s cyc%0d outputs: got %b want %b", k.name(), c, obs, e);
      else passed++;
      pcu += int'(pc_update);
      if (c < last) begin
        @(posedge clk); #1;
      end
    end
    if (stop == 0) begin
      checks++;
      if (pcu !== 1) $display("FAIL %s pc_update count: got %0d want 1", k.name(), pcu);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_align();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = OP_LOAD; alu_bcond = 1'b1; halt_req = 1'b1;
    #3;
    checks++;
    if (obs !== 15'd0) $display("FAIL reset_outputs: got %b want %b", obs, 15'd0);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (obs !== 15'd0) $display("FAIL reset_held: got %b want %b", obs, 15'd0);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_rtype();   run_instr(K_R, 0); run_instr(K_I, 0); endtask
  task automatic test_load();    run_instr(K_LD, 0); run_instr(K_ST, 0); endtask
  task automatic test_branch();  run_instr(K_BRT, 0); run_instr(K_BRNT, 0); endtask
  task automatic test_jal_jalr(); run_instr(K_JAL, 0); run_instr(K_JALR, 0); endtask

  task automatic test_ecall();
    run_instr(K_ECNOP, 0);
    run_instr(K_NOP, 0);
    // ecall with halt request: IF, ID, then stuck halted
    run_instr(K_ECNOP, 1);
    @(posedge clk); #1;
    opcode = OP_ECALL; halt_req = 1'b1; alu_bcond = 1'($urandom);
    #1;
    checks++;
    if (obs !== exp_out(K_ECNOP, 2)) $display("FAIL halt_id: got %b want %b", obs, exp_out(K_ECNOP, 2));
    else passed++;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      opcode = 7'($urandom); halt_req = 1'($urandom); alu_bcond = 1'($urandom);
      #1;
      checks++;
      if (obs !== 15'd1) $display("FAIL halted cyc%0d: got %b want %b", i, obs, 15'd1);
      else passed++;
    end
    reset_align();
    run_instr(K_R, 0);
  endtask

  task automatic test_reset_mid_store();
    run_instr(K_ST, 4);
    checks++;
    if (mem_write !== 1'b1) $display("FAIL store_mem_write: got %b want 1", mem_write);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 15'd0) $display("FAIL mid_reset_drop: got %b want %b", obs, 15'd0);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (obs !== 15'd0) $display("FAIL mid_reset_held: got %b want %b", obs, 15'd0);
    else passed++;
    reset = 1'b0;
    run_instr(K_LD, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) run_instr(kind_e'($urandom_range(0, 9)), 0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++) run_instr(kind_e'(k), 0);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_branch();
    test_jal_jalr();
    test_ecall();
    test_reset_mid_store();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
